// File: rtl/dwconv_tile_merge.sv
// dwconv_tile_merge: buffers one tile row (two output rows) of 2x2 conv tiles and drains it in raster order.
// Optional feature macro: DWCONV_MERGE_RELU_EN clamps negative slots to zero at capture.
module dwconv_tile_merge #(
   parameter int OUT_W = 4,
   parameter int OUT_H = 4,
   parameter int DW    = 8
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic [0:4*DW-1] tile_data,
   input  logic            tile_valid,
   output logic            tile_ready,
   output logic [DW-1:0]   pix_data,
   output logic            pix_valid,
   input  logic            pix_ready,
   output logic            pix_last
);

   localparam int TCW = (OUT_W / 2 > 1) ? $clog2(OUT_W / 2) : 1;
   localparam int TRW = (OUT_H / 2 > 1) ? $clog2(OUT_H / 2) : 1;
   localparam int DCW = $clog2(2 * OUT_W);

   localparam logic [TCW-1:0] TC_LAST = TCW'(OUT_W / 2 - 1);
   localparam logic [TRW-1:0] TR_LAST = TRW'(OUT_H / 2 - 1);
   localparam logic [DCW-1:0] DC_LAST = DCW'(2 * OUT_W - 1);

   typedef enum logic {S_FILL, S_DRAIN} state_t;

   state_t         r_state;
   logic [TCW-1:0] r_tcol;
   logic [TRW-1:0] r_trow;
   logic [DCW-1:0] r_dcnt;

   logic [DW-1:0]  r_top [OUT_W];
   logic [DW-1:0]  r_bot [OUT_W];

   logic [DW-1:0]  w_slot [4];
   logic [DW-1:0]  w_pix;
   logic           w_tile_acc;
   logic           w_pix_acc;

   function automatic logic [DW-1:0] f_capture(input logic [DW-1:0] v);
`ifdef DWCONV_MERGE_RELU_EN
      logic signed [DW-1:0] s;
      s = v;
      f_capture = (s < 0) ? '0 : v;
`else
      f_capture = v;
`endif
   endfunction

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_slot[k] = f_capture(tile_data[k*DW +: DW]);
      end
   end

   // Handshake outputs are forced low while reset is asserted.
   assign tile_ready = (r_state == S_FILL) && !rst_b;
   assign pix_valid  = (r_state == S_DRAIN) && !rst_b;
   assign pix_last   = pix_valid && (r_trow == TR_LAST) && (r_dcnt == DC_LAST);
   assign w_tile_acc = tile_valid && tile_ready;
   assign w_pix_acc  = pix_valid && pix_ready;

   always_comb begin
      w_pix = '0;
      for (int i = 0; i < OUT_W; i++) begin
         if (r_dcnt == DCW'(i))         w_pix = r_top[i];
         if (r_dcnt == DCW'(i + OUT_W)) w_pix = r_bot[i];
      end
   end

   assign pix_data = w_pix;

   always_ff @(posedge clk) begin
      if (rst_b) begin
         r_state <= S_FILL;
         r_tcol  <= '0;
         r_trow  <= '0;
         r_dcnt  <= '0;
      end else begin
         case (r_state)
            S_FILL: begin
               if (w_tile_acc) begin
                  if (r_tcol == TC_LAST) begin
                     r_tcol  <= '0;
                     r_state <= S_DRAIN;
                  end else begin
                     r_tcol <= r_tcol + TCW'(1);
                  end
               end
            end
            default: begin
               if (w_pix_acc) begin
                  if (r_dcnt == DC_LAST) begin
                     r_dcnt  <= '0;
                     r_state <= S_FILL;
                     r_trow  <= (r_trow == TR_LAST) ? '0 : r_trow + TRW'(1);
                  end else begin
                     r_dcnt <= r_dcnt + DCW'(1);
                  end
               end
            end
         endcase
      end
   end

   // Row buffers carry data only, so they are not reset.
   always_ff @(posedge clk) begin
      if (w_tile_acc) begin
         for (int c = 0; c < OUT_W / 2; c++) begin
            if (r_tcol == TCW'(c)) begin
               r_top[2*c]     <= w_slot[0];
               r_top[2*c + 1] <= w_slot[1];
               r_bot[2*c]     <= w_slot[2];
               r_bot[2*c + 1] <= w_slot[3];
            end
         end
      end
   end

endmodule

// File: tb/tb_dwconv_tile_merge.sv
// Directed bench for dwconv_tile_merge (OUT_W = OUT_H = 4, DW = 8).
module tb_dwconv_tile_merge;

   logic        clk;
   logic        rst_b;
   logic [0:31] tile_data;
   logic        tile_valid;
   logic        tile_ready;
   logic [7:0]  pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_last;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] got_q [$];
   logic       last_q [$];

   logic       bp_en      = 1'b0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = '0;
   logic       prev_last  = 1'b0;
   logic       pend_rise  = 1'b0;
   int         row_cnt    = 0;

   dwconv_tile_merge #(.OUT_W(4), .OUT_H(4), .DW(8)) dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .tile_data  (tile_data),
      .tile_valid (tile_valid),
      .tile_ready (tile_ready),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_last   (pix_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: sample at negedge (collect pixels, stall/rise checks), then advance past posedge.
   task automatic step(output logic acc_tile);
      @(negedge clk);
      acc_tile = tile_valid && tile_ready;
      if (rst_b) begin
         row_cnt    = 0;
         pend_rise  = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (pend_rise) check_eq("ready_rise", tile_ready, 1);
         pend_rise = 1'b0;
         if (prev_stall) begin
            check_eq("stall_data", pix_data, prev_data);
            check_eq("stall_last", pix_last, prev_last);
         end
         prev_stall = pix_valid && !pix_ready;
         prev_data  = pix_data;
         prev_last  = pix_last;
         if (pix_valid && pix_ready) begin
            got_q.push_back(pix_data);
            last_q.push_back(pix_last);
            row_cnt++;
            if (row_cnt == 8) begin
               row_cnt   = 0;
               pend_rise = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      pix_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic put_tile(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
      logic acc;
      acc        = 1'b0;
      tile_data  = {a, b, c, d};
      tile_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         step(acc);
         if (acc) break;
      end
      tile_valid = 1'b0;
      if (!acc) check_eq("tile_timeout", 0, 1);
   endtask

   task automatic send_frame(input int base);
      for (int tr = 0; tr < 2; tr++) begin
         for (int tc = 0; tc < 2; tc++) begin
            put_tile(8'(base + (2*tr)*4 + 2*tc),     8'(base + (2*tr)*4 + 2*tc + 1),
                     8'(base + (2*tr+1)*4 + 2*tc),   8'(base + (2*tr+1)*4 + 2*tc + 1));
         end
      end
   endtask

   task automatic wait_pix(input int target);
      logic acc;
      for (int k = 0; k < 2000; k++) begin
         if (got_q.size() >= target) break;
         step(acc);
      end
      if (got_q.size() < target) check_eq("pix_timeout", got_q.size(), target);
   endtask

   task automatic do_reset();
      logic acc;
      rst_b      = 1'b1;
      tile_valid = 1'b0;
      repeat (2) step(acc);
      @(negedge clk);
      check_eq("rst_tile_ready", tile_ready, 0);
      check_eq("rst_pix_valid", pix_valid, 0);
      check_eq("rst_pix_last", pix_last, 0);
      @(posedge clk);
      #1;
      rst_b = 1'b0;
   endtask

   task automatic check_frame(input int base, input int first_val);
      for (int i = 0; i < 16; i++) begin
         check_eq($sformatf("pix_%0d", i), got_q[base + i], 32'(first_val + i));
         check_eq($sformatf("last_%0d", i), last_q[base + i], (i == 15) ? 1 : 0);
      end
   endtask

   initial begin
      int base;
      int cnt;
      int nlast;
      logic acc;
      logic [7:0] exp3 [16];
      logic [7:0] er0, er1;

      rst_b      = 1'b1;
      tile_valid = 1'b0;
      tile_data  = '0;
      pix_ready  = 1'b1;

      // Raster order with latency check
      do_reset();
      @(negedge clk);
      check_eq("ready_after_rst", tile_ready, 1);
      @(posedge clk);
      #1;
      base = got_q.size();
      put_tile(8'd1, 8'd2, 8'd5, 8'd6);
      put_tile(8'd3, 8'd4, 8'd7, 8'd8);
      check_eq("lat_valid", pix_valid, 1);
      check_eq("lat_pix0", pix_data, 1);
      check_eq("lat_ready", tile_ready, 0);
      put_tile(8'd9, 8'd10, 8'd13, 8'd14);
      put_tile(8'd11, 8'd12, 8'd15, 8'd16);
      wait_pix(base + 16);
      check_frame(base, 1);

      // Backpressure
      do_reset();
      base  = got_q.size();
      bp_en = 1'b1;
      send_frame(1);
      wait_pix(base + 16);
      repeat (4) step(acc);
      bp_en     = 1'b0;
      pix_ready = 1'b1;
      check_eq("bp_count", got_q.size() - base, 16);
      check_frame(base, 1);

      // Tiles presented during drain
      do_reset();
      base = got_q.size();
      put_tile(8'd1, 8'd2, 8'd5, 8'd6);
      put_tile(8'd3, 8'd4, 8'd7, 8'd8);
      tile_data  = {8'hAA, 8'hAA, 8'hAA, 8'hAA};
      tile_valid = 1'b1;
      cnt = 0;
      acc = 1'b0;
      for (int k = 0; k < 50; k++) begin
         step(acc);
         if (acc) break;
         cnt++;
      end
      tile_valid = 1'b0;
      check_eq("drain_ready_low", cnt, 8);
      put_tile(8'd11, 8'd12, 8'd15, 8'd16);
      wait_pix(base + 16);
      exp3 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
               8'hAA, 8'hAA, 8'd11, 8'd12, 8'hAA, 8'hAA, 8'd15, 8'd16};
      for (int i = 0; i < 16; i++) begin
         check_eq($sformatf("drain_pix_%0d", i), got_q[base + i], exp3[i]);
      end

      // Reset mid-drain
      do_reset();
      base = got_q.size();
      put_tile(8'd1, 8'd2, 8'd5, 8'd6);
      put_tile(8'd3, 8'd4, 8'd7, 8'd8);
      wait_pix(base + 3);
      rst_b = 1'b1;
      repeat (3) step(acc);
      rst_b = 1'b0;
      check_eq("rst_mid_count", got_q.size() - base, 3);
      check_eq("rst_mid_pix2", got_q[base + 2], 3);
      base = got_q.size();
      send_frame(21);
      wait_pix(base + 16);
      check_frame(base, 21);

      // ReLU clamp at capture
      do_reset();
      base = got_q.size();
      put_tile(8'h80, 8'hFF, 8'h01, 8'h7F);
      put_tile(8'd3, 8'd4, 8'd7, 8'd8);
      wait_pix(base + 8);
`ifdef DWCONV_MERGE_RELU_EN
      er0 = 8'h00;
      er1 = 8'h00;
`else
      er0 = 8'h80;
      er1 = 8'hFF;
`endif
      check_eq("relu_p0", got_q[base + 0], er0);
      check_eq("relu_p1", got_q[base + 1], er1);
      check_eq("relu_p2", got_q[base + 2], 3);
      check_eq("relu_p4", got_q[base + 4], 8'h01);
      check_eq("relu_p5", got_q[base + 5], 8'h7F);

      // Frame wrap: two back-to-back frames
      do_reset();
      base = got_q.size();
      send_frame(1);
      send_frame(1);
      wait_pix(base + 32);
      nlast = 0;
      for (int i = 0; i < 32; i++) if (last_q[base + i]) nlast++;
      check_eq("wrap_nlast", nlast, 2);
      check_eq("wrap_last0", last_q[base + 15], 1);
      check_eq("wrap_last1", last_q[base + 31], 1);
      check_eq("wrap_f2_pix0", got_q[base + 16], 1);
      check_eq("wrap_f2_pix15", got_q[base + 31], 16);
      repeat (2) step(acc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
